// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter.
// State encoding, requester count and a one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int NREQ = 4;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Rotate-priority picker: first set req bit starting at ptr, wrapping mod 4.
// Combinational only; any is low when no request is pending.
module mux4_rr_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] pick,
    output logic       any
);

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        pick = ptr;
        any  = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                pick = ptr + 2'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4to1_case.sv
// Single-bit 4:1 multiplexer shared by the arbitrated requesters.
// Purely combinational; select is supplied by the arbiter.
module mux4to1_case (
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic [1:0] sel,
    output logic       out
);

    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with hold-time limit driving a shared 4:1 mux.
// Grant, select and timeout are registered; out is in[sel] gated by valid.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       out,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_SAT = '1;

    logic             state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [1:0] pick;
    logic       any;
    logic       own_rel;
    logic       own_drop;
    logic       at_limit;
    logic       mux_y;

    mux4_rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    assign own_rel  = rel[sel_q];
    assign own_drop = ~req[sel_q];
    assign at_limit = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot4(pick);
                    sel_d   = pick;
                    hold_d  = CNT_W'(1);
                end
            end
            default: begin
                if (own_rel || own_drop || at_limit) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    ptr_d     = sel_q + 2'd1;
                    // A voluntary release in the same cycle masks the timeout.
                    timeout_d = at_limit && !own_rel && !own_drop;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    mux4to1_case u_mux (
        .in0 (in[0]),
        .in1 (in[1]),
        .in2 (in[2]),
        .in3 (in[3]),
        .sel (sel_q),
        .out (mux_y)
    );

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign valid   = (state_q == ST_GRANT);
    assign out     = valid & mux_y;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a 4-cycle hold limit.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       out;
    logic       timeout;

    int errs;
    int checks;

    mux4_rr_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .in      (in),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .out     (out),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g,
                             input logic [1:0] s);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic chk_idle(input string tag, input logic to);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".out"}, 32'(out), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    logic [3:0] oh;

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 4'b1111;
        rel    = 4'b0000;
        in     = 4'b1111;

        // Reset holds everything low even with all requests active.
        #3;
        chk_idle("rst_async", 1'b0);
        chk("rst_async.sel", 32'(sel), 32'd0);
        tick();
        tick();
        chk_idle("rst_clk", 1'b0);
        chk("rst_clk.sel", 32'(sel), 32'd0);

        // Single request on requester 2.
        req   = 4'b0100;
        in    = 4'b0100;
        rst_n = 1'b1;
        tick();
        chk_grant("single", 4'b0100, 2'd2);
        chk("single.out1", 32'(out), 32'd1);
        in = 4'b1011;
        #1;
        chk("single.out0", 32'(out), 32'd0);
        in  = 4'b0100;
        rel = 4'b0101;
        tick();
        chk_idle("single_rel", 1'b0);
        chk("single_rel.sel", 32'(sel), 32'd2);
        rel = 4'b0000;

        // ptr now 3: requester 3 wins over 0.
        req = 4'b1001;
        tick();
        chk_grant("ptr3", 4'b1000, 2'd3);
        rel = 4'b1000;
        tick();
        chk_idle("ptr3_rel", 1'b0);
        rel = 4'b0000;

        // Fairness: all request, owner releases on its second cycle.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            tick();
            chk_grant($sformatf("fair%0d.c1", k), oh, 2'(k % 4));
            tick();
            chk_grant($sformatf("fair%0d.c2", k), oh, 2'(k % 4));
            rel = oh;
            tick();
            chk_idle($sformatf("fair%0d.idle", k), 1'b0);
            rel = 4'b0000;
        end

        // Timeout: only requester 1, no release (ptr is 1).
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_grant($sformatf("to.c%0d", c), 4'b0010, 2'd1);
        end
        tick();
        chk_idle("to.end", 1'b1);
        tick();
        chk_grant("to.regrant", 4'b0010, 2'd1);

        // Limit and release in the same cycle: no timeout.
        tick();
        tick();
        tick();
        chk_grant("tie.c4", 4'b0010, 2'd1);
        rel = 4'b0010;
        tick();
        chk_idle("tie.end", 1'b0);
        rel = 4'b0000;

        // Owner 0 (ptr 2 wraps); non-owner rel and req are ignored.
        req = 4'b0001;
        tick();
        chk_grant("drop.c1", 4'b0001, 2'd0);
        rel = 4'b1000;
        tick();
        chk_grant("drop.c2", 4'b0001, 2'd0);
        rel = 4'b0000;
        req = 4'b1001;
        tick();
        chk_grant("drop.c3", 4'b0001, 2'd0);
        req = 4'b0000;
        tick();
        chk_idle("drop.end", 1'b0);

        // Async reset mid-grant (ptr is 1 before reset).
        req = 4'b0010;
        in  = 4'b0010;
        tick();
        chk_grant("arst.pre", 4'b0010, 2'd1);
        chk("arst.pre.out", 32'(out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst.low", 1'b0);
        chk("arst.low.sel", 32'(sel), 32'd0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        chk_grant("arst.post", 4'b0001, 2'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one 4:1 single-bit mux datapath among four requesters. It accepts per-requester request/release handshakes, grants exactly one requester at a time, and drives the mux select from its registered grant state. A hold counter enforces a maximum tenure per grant. The block sits directly in front of the team's 4:1 mux, which it instantiates.

## Interface
- HOLD_MAX, 15: maximum cycles a grant may be held; 0 disables the timeout.
- CNT_W, 4: hold counter width; must satisfy 2^CNT_W > HOLD_MAX.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; level, held until granted and finished.
- rel  input  4  release per requester; single-cycle pulse, honoured only for the current owner.
- in  input  4  data bit per requester (mux inputs in0..in3).
- gnt  output  4  one-hot registered grant; 0 when idle.
- sel  output  2  registered mux select (index of owner).
- valid  output  1  high while a grant is active (state GRANT).
- out  output  1  in[sel] when valid, else 0.
- timeout  output  1  single-cycle pulse when a grant is forcibly ended by the hold counter.

## Operation
- States: IDLE, GRANT. Internal: ptr[1:0] (next highest-priority index), hold_cnt[CNT_W-1:0].
- IDLE: if req != 0, pick the first set req bit scanning ptr, ptr+1, ... (mod 4); next cycle: state GRANT, gnt = onehot(pick), sel = pick, hold_cnt = 1. If req == 0, stay IDLE.
- GRANT: release when any of: rel[sel] = 1; req[sel] = 0; HOLD_MAX != 0 and hold_cnt == HOLD_MAX. Otherwise hold_cnt increments (saturates at its max value when HOLD_MAX = 0).
- On release: next cycle state IDLE, gnt = 0, valid = 0, ptr = sel + 1 (2-bit wrap, 3 -> 0). sel keeps its last value.
- timeout = 1 for the cycle after release only when the hold limit was the sole release cause; rel or req drop in the same cycle as limit wins (no timeout).
- rel bits for non-owners are ignored. req bits of non-owners never pre-empt.
- out is combinational: in[sel] gated by valid; no registering of data.
- Reset (async assert, sync-free deassert): state IDLE, gnt 0, sel 0, valid 0, timeout 0, ptr 0, hold_cnt 0; out therefore 0.

## Timing
- Grant latency: req seen in IDLE at edge N -> gnt/sel/valid high after edge N (visible cycle N+1).
- Release latency: release condition at edge M -> valid low after edge M; one mandatory IDLE cycle before the next grant (minimum re-grant gap 1 cycle).
- Maximum tenure with timeout enabled: HOLD_MAX cycles of valid.
- Worst-case wait for a continuously requesting requester: 3 x (HOLD_MAX + 1) + 1 cycles.
- Reset mid-GRANT: gnt, valid, out drop to 0 immediately on rst_n low, without waiting for clk.

## Structure
- Shared package: state encoding constants (IDLE = 1'b0, GRANT = 1'b1) and requester count (4).
- Sub-module mux4_rr_pick: combinational rotate-priority picker (req[3:0], ptr[1:0] -> pick[1:0], any).
- Data path reuses the existing mux4to1_case instance with sel from this block; gating by valid at top level.

## Test plan
- Reset: rst_n low with req = 4'b1111 -> gnt 0, sel 0, valid 0, out 0, timeout 0.
- Single request: req = 4'b0100 at cycle 1, in = 4'b0100 -> cycle 2 gnt 4'b0100, sel 2, valid 1, out 1; rel[2] pulse -> next cycle valid 0, ptr 3.
- Fairness: req = 4'b1111 held, rel of owner pulsed on each second grant cycle -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Timeout: HOLD_MAX = 4, only req[1] held, no rel -> valid high exactly 4 cycles, timeout pulse 1 cycle, one IDLE, re-grant to 1.
- Request drop and ignored release: owner 0 drops req -> release next edge, timeout 0; rel[3] pulsed during owner 0 tenure -> no effect.
- Async reset mid-grant: rst_n low between clock edges while gnt = 4'b0010 -> gnt, valid, out 0 immediately; after release of rst_n, first grant follows ptr 0 priority.
